// File: rtl/alu_pkg.sv
// Shared ALU flag types and the Thumb condition-code evaluator used by IT tracking
// and the conditional branch unit.
package alu_pkg;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

   typedef enum logic [3:0] {
      CondEq = 4'h0,
      CondNe = 4'h1,
      CondCs = 4'h2,
      CondCc = 4'h3,
      CondMi = 4'h4,
      CondPl = 4'h5,
      CondVs = 4'h6,
      CondVc = 4'h7,
      CondHi = 4'h8,
      CondLs = 4'h9,
      CondGe = 4'hA,
      CondLt = 4'hB,
      CondGt = 4'hC,
      CondLe = 4'hD,
      CondAl = 4'hE,
      CondNv = 4'hF
   } cond_e;

   localparam logic [3:0] IT_AL = 4'hE;

   function automatic logic cond_eval(cond_e cond, alu_flags_t f);
      logic pass;
      pass = 1'b1;
      unique case (cond)
         CondEq: pass = f.z;
         CondNe: pass = !f.z;
         CondCs: pass = f.c;
         CondCc: pass = !f.c;
         CondMi: pass = f.n;
         CondPl: pass = !f.n;
         CondVs: pass = f.v;
         CondVc: pass = !f.v;
         CondHi: pass = f.c && !f.z;
         CondLs: pass = !f.c || f.z;
         CondGe: pass = (f.n == f.v);
         CondLt: pass = (f.n != f.v);
         CondGt: pass = !f.z && (f.n == f.v);
         CondLe: pass = f.z || (f.n != f.v);
         CondAl: pass = 1'b1;
         CondNv: pass = 1'b1;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/it_state_ctrl_if.sv
// Retire-side controls and IT status outputs of the IT-state tracker.
interface it_state_ctrl_if;
   import alu_pkg::*;

   alu_flags_t  flags;
   logic        it_load;
   logic [3:0]  it_firstcond;
   logic [3:0]  it_mask;
   logic        instr_adv;
   logic        flush;
   logic [7:0]  itstate;
   logic        in_it;
   logic        last_in_it;
   logic [3:0]  cur_cond;
   logic        cond_pass;
   logic        illegal_it;

   modport master (
      output flags, it_load, it_firstcond, it_mask, instr_adv, flush,
      input  itstate, in_it, last_in_it, cur_cond, cond_pass, illegal_it
   );

   modport slave (
      input  flags, it_load, it_firstcond, it_mask, instr_adv, flush,
      output itstate, in_it, last_in_it, cur_cond, cond_pass, illegal_it
   );

endinterface

// File: rtl/cond_check.sv
// Combinational condition-code check of a 4-bit cond against APSR flags.
module cond_check
   import alu_pkg::*;
(
   input  logic [3:0] cond_i,
   input  alu_flags_t flags_i,
   output logic       pass_o
);

   assign pass_o = cond_eval(cond_e'(cond_i), flags_i);

endmodule

// File: rtl/it_state_ctrl.sv
// Thumb ITSTATE tracker: loads on IT retire, advances per retired instruction and
// reports whether the current instruction's condition passes.
module it_state_ctrl
   import alu_pkg::*;
#(
   parameter bit CHECK_ILLEGAL = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   it_state_ctrl_if.slave  bus
);

   logic [7:0] itstate_q, itstate_d;
   logic       illegal_it_q, illegal_it_d;
   logic       in_it;
   logic       illegal_load;
   logic [7:0] itstate_adv;

   assign in_it = (itstate_q[3:0] != 4'b0000);

   // The final instruction of a block leaves no mask bits below the terminating 1.
   assign itstate_adv = (itstate_q[2:0] == 3'b000) ? 8'h00 :
                        {itstate_q[7:5], itstate_q[3:0], 1'b0};

   always_comb begin
      illegal_load = 1'b0;
      if (CHECK_ILLEGAL) begin
         illegal_load = in_it ||
                        (bus.it_mask == 4'b0000) ||
                        (bus.it_firstcond == 4'b1111) ||
                        ((bus.it_firstcond == IT_AL) && (bus.it_mask != 4'b1000));
      end
   end

   always_comb begin
      itstate_d    = itstate_q;
      illegal_it_d = 1'b0;
      if (bus.flush) begin
         itstate_d = 8'h00;
      end else if (bus.it_load && !illegal_load) begin
         // The retiring IT instruction is itself the advance, so instr_adv is ignored.
         itstate_d = {bus.it_firstcond, bus.it_mask};
      end else begin
         illegal_it_d = bus.it_load;
         if (bus.instr_adv && in_it) begin
            itstate_d = itstate_adv;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         itstate_q    <= 8'h00;
         illegal_it_q <= 1'b0;
      end else begin
         itstate_q    <= itstate_d;
         illegal_it_q <= illegal_it_d;
      end
   end

   assign bus.itstate    = itstate_q;
   assign bus.in_it      = in_it;
   assign bus.last_in_it = (itstate_q[3:0] == 4'b1000);
   assign bus.cur_cond   = in_it ? itstate_q[7:4] : IT_AL;
   assign bus.illegal_it = illegal_it_q;

   cond_check u_cond_check (
      .cond_i  (bus.cur_cond),
      .flags_i (bus.flags),
      .pass_o  (bus.cond_pass)
   );

endmodule

// File: tb/tb_it_state_ctrl.sv
// Scoreboard bench for it_state_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_it_state_ctrl;
   import alu_pkg::*;

   typedef struct {
      string      name;
      logic [7:0] it;
      logic       in_it;
      logic       last;
      logic [3:0] cc;
      logic       pass;
      logic       ill;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   exp_t sb[$];

   it_state_ctrl_if bus ();

   it_state_ctrl #(
      .CHECK_ILLEGAL (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input string name, input logic ld, input logic [3:0] fc,
                       input logic [3:0] mask, input logic adv, input logic fl,
                       input logic [3:0] f, input logic rst_pulse,
                       input logic [7:0] e_it, input logic e_in, input logic e_last,
                       input logic [3:0] e_cc, input logic e_pass, input logic e_ill);
      exp_t e;
      @(posedge clk);
      #1;
      bus.it_load      = ld;
      bus.it_firstcond = fc;
      bus.it_mask      = mask;
      bus.instr_adv    = adv;
      bus.flush        = fl;
      bus.flags        = alu_flags_t'(f);
      e.name  = name;
      e.it    = e_it;
      e.in_it = e_in;
      e.last  = e_last;
      e.cc    = e_cc;
      e.pass  = e_pass;
      e.ill   = e_ill;
      sb.push_back(e);
      if (rst_pulse) begin
         #1 rst_n = 1'b0;
         #1 rst_n = 1'b1;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.itstate !== e.it || bus.in_it !== e.in_it || bus.last_in_it !== e.last ||
                bus.cur_cond !== e.cc || bus.cond_pass !== e.pass ||
                bus.illegal_it !== e.ill) begin
               n_fail++;
               $display("FAIL %s: got it=%h in=%b last=%b cc=%h pass=%b ill=%b, want it=%h in=%b last=%b cc=%h pass=%b ill=%b",
                        e.name, bus.itstate, bus.in_it, bus.last_in_it, bus.cur_cond,
                        bus.cond_pass, bus.illegal_it, e.it, e.in_it, e.last, e.cc,
                        e.pass, e.ill);
            end
         end
      end
   end

   initial begin : stim
      n_checks = 0;
      n_fail   = 0;
      rst_n            = 1'b0;
      bus.it_load      = 1'b0;
      bus.it_firstcond = 4'h0;
      bus.it_mask      = 4'h0;
      bus.instr_adv    = 1'b0;
      bus.flush        = 1'b0;
      bus.flags        = alu_flags_t'(4'b0000);
      #12 rst_n = 1'b1;

      //   name          ld fc    mask  adv fl flags   rp  it     in last cc    pass ill
      step("reset",      0, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      // ITTE EQ with Z=1
      step("itte_ld",    1, 4'h0, 4'h6, 0, 0, 4'b0100, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      step("itte_1",     0, 4'h0, 4'h0, 1, 0, 4'b0100, 0, 8'h06, 1, 0, 4'h0, 1, 0);
      step("itte_2",     0, 4'h0, 4'h0, 1, 0, 4'b0100, 0, 8'h0C, 1, 0, 4'h0, 1, 0);
      step("itte_3",     0, 4'h0, 4'h0, 1, 0, 4'b0100, 0, 8'h18, 1, 1, 4'h1, 0, 0);
      step("itte_end",   0, 4'h0, 4'h0, 0, 0, 4'b0100, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      // ITE GT with N=1 V=0 Z=0
      step("ite_ld",     1, 4'hC, 4'hC, 0, 0, 4'b1000, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      step("ite_1",      0, 4'h0, 4'h0, 1, 0, 4'b1000, 0, 8'hCC, 1, 0, 4'hC, 0, 0);
      step("ite_2",      0, 4'h0, 4'h0, 1, 0, 4'b1000, 0, 8'hD8, 1, 1, 4'hD, 1, 0);
      step("ite_end",    0, 4'h0, 4'h0, 0, 0, 4'b1000, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      // Illegal loads
      step("ill_setup",  1, 4'h0, 4'h8, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      step("ill_inblk",  1, 4'h1, 4'h8, 0, 0, 4'b0000, 0, 8'h08, 1, 1, 4'h0, 0, 0);
      step("ill_pulse",  0, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 8'h08, 1, 1, 4'h0, 0, 1);
      step("ill_clear",  0, 4'h0, 4'h0, 1, 0, 4'b0000, 0, 8'h08, 1, 1, 4'h0, 0, 0);
      step("ill_mask0",  1, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      step("ill_m0_p",   1, 4'hF, 4'h8, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 1);
      step("ill_nv_p",   1, 4'hE, 4'h4, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 1);
      step("ill_al_p",   1, 4'hE, 4'h8, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 1);
      step("al_blk",     0, 4'h0, 4'h0, 1, 0, 4'b0000, 0, 8'hE8, 1, 1, 4'hE, 1, 0);
      // Flush priority and load/advance collisions
      step("fl_setup",   1, 4'h0, 4'h6, 0, 0, 4'b0100, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      step("fl_mid",     0, 4'h0, 4'h0, 1, 0, 4'b0100, 0, 8'h06, 1, 0, 4'h0, 1, 0);
      step("fl_all",     1, 4'h1, 4'h8, 1, 1, 4'b0100, 0, 8'h0C, 1, 0, 4'h0, 1, 0);
      step("fl_chk",     1, 4'h1, 4'h8, 1, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      step("ld_adv",     1, 4'h0, 4'h8, 1, 0, 4'b0000, 0, 8'h18, 1, 1, 4'h1, 1, 0);
      step("ill_adv",    0, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 1);
      // Asynchronous reset inside a block
      step("rst_ld",     1, 4'h0, 4'h6, 0, 0, 4'b0100, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      step("rst_async",  0, 4'h0, 4'h0, 0, 0, 4'b0000, 1, 8'h00, 0, 0, 4'hE, 1, 0);
      step("rst_after",  0, 4'h0, 4'h0, 1, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      // ITTTT CS with varying C
      step("cs_ld",      1, 4'h2, 4'h1, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      step("cs_1",       0, 4'h0, 4'h0, 1, 0, 4'b0010, 0, 8'h21, 1, 0, 4'h2, 1, 0);
      step("cs_2",       0, 4'h0, 4'h0, 1, 0, 4'b0000, 0, 8'h22, 1, 0, 4'h2, 0, 0);
      step("cs_3",       0, 4'h0, 4'h0, 1, 0, 4'b1111, 0, 8'h24, 1, 0, 4'h2, 1, 0);
      step("cs_4",       0, 4'h0, 4'h0, 1, 0, 4'b1101, 0, 8'h28, 1, 1, 4'h2, 0, 0);
      step("cs_end",     0, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      // ITEEE HI / LS
      step("hi_ld",      1, 4'h8, 4'hF, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 0);
      step("hi_1",       0, 4'h0, 4'h0, 1, 0, 4'b0010, 0, 8'h8F, 1, 0, 4'h8, 1, 0);
      step("ls_2",       0, 4'h0, 4'h0, 1, 0, 4'b0110, 0, 8'h9E, 1, 0, 4'h9, 1, 0);
      step("ls_3",       0, 4'h0, 4'h0, 1, 0, 4'b0010, 0, 8'h9C, 1, 0, 4'h9, 0, 0);
      step("ls_4",       0, 4'h0, 4'h0, 1, 0, 4'b0000, 0, 8'h98, 1, 1, 4'h9, 1, 0);
      step("hi_end",     0, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'hE, 1, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
